alu_arbiter: RTL and testbench

Shares the single RISC-V `ALU` instance between two requesters: port 0, the core execute stage, and port 1, the auxiliary/debug execute port. It uses a valid/ready request handshake, round-robin arbitration and a two-stage registered issue/response pipeline. The block drives the `ALU` inputs from an issue register and captures `ALU_result`/`branch` into a response register tagged with the owning requester. This gives a fixed 2-cycle request-to-response latency and a throughput of one operation per cycle.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two
// requesters, with registered issue and response stages (2-cycle latency).
// Ports: clock/reset (async, active-low); r0_*/r1_* request handshake,
// payload and response strobe/result; alu_* drive to / capture from the ALU.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [CTRL_WIDTH-1:0] r0_ctrl,
  input  logic                  r0_branch_op,
  input  logic [DATA_WIDTH-1:0] r0_op_a,
  input  logic [DATA_WIDTH-1:0] r0_op_b,
  output logic                  r0_resp_valid,
  output logic [DATA_WIDTH-1:0] r0_result,
  output logic                  r0_branch,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [CTRL_WIDTH-1:0] r1_ctrl,
  input  logic                  r1_branch_op,
  input  logic [DATA_WIDTH-1:0] r1_op_a,
  input  logic [DATA_WIDTH-1:0] r1_op_b,
  output logic                  r1_resp_valid,
  output logic [DATA_WIDTH-1:0] r1_result,
  output logic                  r1_branch,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  output logic                  alu_branch_op,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_branch
);

  logic                  last_grant;
  logic                  iss_valid;
  logic                  iss_id;
  logic [CTRL_WIDTH-1:0] iss_ctrl;
  logic                  iss_branch_op;
  logic [DATA_WIDTH-1:0] iss_op_a;
  logic [DATA_WIDTH-1:0] iss_op_b;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_branch;

  logic                  acc0;
  logic                  acc1;
  logic                  nxt_valid;
  logic                  nxt_id;
  logic [CTRL_WIDTH-1:0] nxt_ctrl;
  logic                  nxt_branch_op;
  logic [DATA_WIDTH-1:0] nxt_op_a;
  logic [DATA_WIDTH-1:0] nxt_op_b;
  logic                  nxt_grant;

  // With both valid, the port not granted last wins.
  assign r0_ready = !r1_valid || last_grant;
  assign r1_ready = !r0_valid || !last_grant;

  assign acc0 = r0_valid && r0_ready;
  assign acc1 = r1_valid && r1_ready;

  // Idle cycles clear the payload so the ALU sees ADD 0+0.
  always_comb begin
    nxt_valid     = 1'b0;
    nxt_id        = 1'b0;
    nxt_ctrl      = '0;
    nxt_branch_op = 1'b0;
    nxt_op_a      = '0;
    nxt_op_b      = '0;
    nxt_grant     = last_grant;
    unique case (1'b1)
      acc0: begin
        nxt_valid     = 1'b1;
        nxt_id        = 1'b0;
        nxt_ctrl      = r0_ctrl;
        nxt_branch_op = r0_branch_op;
        nxt_op_a      = r0_op_a;
        nxt_op_b      = r0_op_b;
        nxt_grant     = 1'b0;
      end
      acc1: begin
        nxt_valid     = 1'b1;
        nxt_id        = 1'b1;
        nxt_ctrl      = r1_ctrl;
        nxt_branch_op = r1_branch_op;
        nxt_op_a      = r1_op_a;
        nxt_op_b      = r1_op_b;
        nxt_grant     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant    <= 1'b1;
      iss_valid     <= 1'b0;
      iss_id        <= 1'b0;
      iss_ctrl      <= '0;
      iss_branch_op <= 1'b0;
      iss_op_a      <= '0;
      iss_op_b      <= '0;
    end else begin
      last_grant    <= nxt_grant;
      iss_valid     <= nxt_valid;
      iss_id        <= nxt_id;
      iss_ctrl      <= nxt_ctrl;
      iss_branch_op <= nxt_branch_op;
      iss_op_a      <= nxt_op_a;
      iss_op_b      <= nxt_op_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_branch <= 1'b0;
    end else begin
      rsp_valid  <= iss_valid;
      rsp_id     <= iss_id;
      rsp_result <= alu_result;
      rsp_branch <= alu_branch;
    end
  end

  assign alu_ctrl      = iss_ctrl;
  assign alu_branch_op = iss_branch_op;
  assign alu_op_a      = iss_op_a;
  assign alu_op_b      = iss_op_b;

  assign r0_resp_valid = rsp_valid && !rsp_id;
  assign r1_resp_valid = rsp_valid && rsp_id;
  assign r0_result     = rsp_result;
  assign r1_result     = rsp_result;
  assign r0_branch     = rsp_branch;
  assign r1_branch     = rsp_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU
// and a scoreboard of expected responses keyed by due cycle.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid, r0_ready, r0_branch_op, r0_resp_valid, r0_branch;
  logic [5:0]  r0_ctrl;
  logic [31:0] r0_op_a, r0_op_b, r0_result;
  logic        r1_valid, r1_ready, r1_branch_op, r1_resp_valid, r1_branch;
  logic [5:0]  r1_ctrl;
  logic [31:0] r1_op_a, r1_op_b, r1_result;
  logic [5:0]  alu_ctrl;
  logic        alu_branch_op, alu_branch;
  logic [31:0] alu_op_a, alu_op_b, alu_result;

  alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(6)) dut (
    .clock(clock), .reset(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctrl(r0_ctrl),
    .r0_branch_op(r0_branch_op), .r0_op_a(r0_op_a), .r0_op_b(r0_op_b),
    .r0_resp_valid(r0_resp_valid), .r0_result(r0_result),
    .r0_branch(r0_branch),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctrl(r1_ctrl),
    .r1_branch_op(r1_branch_op), .r1_op_a(r1_op_a), .r1_op_b(r1_op_b),
    .r1_resp_valid(r1_resp_valid), .r1_result(r1_result),
    .r1_branch(r1_branch),
    .alu_ctrl(alu_ctrl), .alu_branch_op(alu_branch_op),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_result(alu_result), .alu_branch(alu_branch)
  );

  always #5 clock = ~clock;

  // Behavioural combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      6'b000000: alu_result = alu_op_a + alu_op_b;
      6'b001000: alu_result = alu_op_a - alu_op_b;
      6'b000010: alu_result = {31'd0, $signed(alu_op_a) < $signed(alu_op_b)};
      6'b000011: alu_result = {31'd0, alu_op_a < alu_op_b};
      6'b010000: alu_result = {31'd0, alu_op_a == alu_op_b};
      default:   alu_result = '0;
    endcase
    alu_branch = alu_branch_op && (alu_op_a == alu_op_b);
  end

  typedef struct {
    logic        v;
    logic [5:0]  c;
    logic        bo;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic        eb;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        br;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic m_last = 1'b1;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic req_t mk(input logic v, input logic [5:0] c,
                              input logic bo, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e,
                              input logic eb);
    req_t r;
    r.v = v; r.c = c; r.bo = bo; r.a = a; r.b = b; r.e = e; r.eb = eb;
    return r;
  endfunction

  req_t idle;
  assign idle = mk(1'b0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

  // Response monitor: every strobe must match the oldest expectation
  // and arrive exactly on its due cycle.
  always @(negedge clock) begin
    exp_t e;
    if (r0_resp_valid || r1_resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", {r1_resp_valid, r0_resp_valid}, 0);
      end else begin
        e = q.pop_front();
        chk("resp_strobe", {r1_resp_valid, r0_resp_valid},
            e.id ? 2'b10 : 2'b01);
        chk("resp_due", cyc, e.due);
        chk("resp_result", e.id ? r1_result : r0_result, e.res);
        chk("resp_branch", e.id ? r1_branch : r0_branch, e.br);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("missing_resp", 0, {e.id, 1'b1});
    end
  end

  task automatic cycle(input req_t p0, input req_t p1);
    exp_t e;
    r0_valid = p0.v; r0_ctrl = p0.c; r0_branch_op = p0.bo;
    r0_op_a = p0.a; r0_op_b = p0.b;
    r1_valid = p1.v; r1_ctrl = p1.c; r1_branch_op = p1.bo;
    r1_op_a = p1.a; r1_op_b = p1.b;
    #1;
    chk("r0_ready", r0_ready, !p1.v || m_last);
    chk("r1_ready", r1_ready, !p0.v || !m_last);
    if (rst_n) begin
      if (p0.v && (!p1.v || m_last)) begin
        e.id = 1'b0; e.res = p0.e; e.br = p0.eb; e.due = cyc + 2;
        q.push_back(e);
        m_last = 1'b0;
      end else if (p1.v && (!p0.v || !m_last)) begin
        e.id = 1'b1; e.res = p1.e; e.br = p1.eb; e.due = cyc + 2;
        q.push_back(e);
        m_last = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_last = 1'b1;
    #1;
    chk("rst_r0_resp", r0_resp_valid, 0);
    chk("rst_r1_resp", r1_resp_valid, 0);
    chk("rst_result", {r1_result, r0_result}, 0);
    chk("rst_branch", {r1_branch, r0_branch}, 0);
    chk("rst_alu", {alu_ctrl, alu_branch_op, alu_op_a, alu_op_b}, 0);
    @(negedge clock);
    cycle(mk(1, 6'd0, 0, 32'd1, 32'd1, 32'd2, 0),
          mk(1, 6'd0, 0, 32'd3, 32'd3, 32'd6, 0));
    cycle(mk(1, 6'd0, 0, 32'd1, 32'd1, 32'd2, 0),
          mk(1, 6'd0, 0, 32'd3, 32'd3, 32'd6, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    req_t b;
    int   k0;
    int   k1;
    r0_valid = 0; r0_ctrl = 0; r0_branch_op = 0; r0_op_a = 0; r0_op_b = 0;
    r1_valid = 0; r1_ctrl = 0; r1_branch_op = 0; r1_op_a = 0; r1_op_b = 0;
    @(negedge clock);
    do_reset();

    // Port 0 alone: ADD 4+5.
    cycle(mk(1, 6'b000000, 0, 32'd4, 32'd5, 32'd9, 0), idle);
    cycle(idle, idle);
    cycle(idle, idle);

    // Contention right after reset: r0 SUB first, then r1 BEQ.
    do_reset();
    b = mk(1, 6'b010000, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1);
    cycle(mk(1, 6'b001000, 0, 32'd5, 32'd4, 32'd1, 0), b);
    cycle(idle, b);
    cycle(idle, idle);
    cycle(idle, idle);

    // Sustained contention: grants alternate, payload advances on accept.
    k0 = 0;
    k1 = 0;
    for (int i = 0; i < 6; i++) begin
      logic win;
      win = m_last ? 1'b0 : 1'b1;
      cycle(mk(1, 6'b000000, 0, k0 + 1, 32'd100, k0 + 101, 0),
            mk(1, 6'b001000, 0, 32'd50 + k1, 32'd3, 32'd47 + k1, 0));
      if (win) k1++;
      else k0++;
    end
    chk("alt_count", {k0[7:0], k1[7:0]}, {8'd3, 8'd3});
    cycle(idle, idle);
    cycle(idle, idle);

    // Port 1 alone, idle ALU drive, then port 0 wins contention.
    for (int i = 1; i <= 3; i++)
      cycle(idle, mk(1, 6'b000000, 0, i, i, 2 * i, 0));
    cycle(idle, idle);
    chk("idle_alu", {alu_ctrl, alu_branch_op, alu_op_a, alu_op_b}, 0);
    b = mk(1, 6'b000000, 0, 32'd9, 32'd9, 32'd18, 0);
    cycle(mk(1, 6'b000000, 0, 32'd7, 32'd8, 32'd15, 0), b);
    cycle(idle, b);
    cycle(idle, idle);

    // Unsigned vs signed set-less-than on port 1.
    cycle(idle, mk(1, 6'b000011, 0, 32'd4, 32'hFFFFFFFF, 32'd1, 0));
    cycle(idle, mk(1, 6'b000010, 0, 32'd4, 32'hFFFFFFFF, 32'd0, 0));
    cycle(idle, idle);
    cycle(idle, idle);

    // Reset with an operation in flight: it must vanish.
    cycle(mk(1, 6'b000000, 0, 32'd4, 32'd5, 32'd9, 0), idle);
    do_reset();
    b = mk(1, 6'b000000, 0, 32'd2, 32'd2, 32'd4, 0);
    cycle(mk(1, 6'b000000, 0, 32'd1, 32'd1, 32'd2, 0), b);
    cycle(idle, b);

    for (int i = 0; i < 6 && q.size() > 0; i++) cycle(idle, idle);
    cycle(idle, idle);
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
